ram_bist_controller: RTL

//  Built-in self-test initiator for the single-port RAM: drives data, write_addr,

---
 rtl/ram_bist_pkg.sv | 7 +
 rtl/ram_bist_exp_pipe.sv | 26 ++
 rtl/ram_bist_controller.sv | 85 ++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM state type and test-pattern generator for the RAM BIST controller
package ram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] seed, input logic p);
    return (a ^ seed) ^ {32{p}};
  endfunction
endpackage

// File: rtl/ram_bist_exp_pipe.sv
// ram_bist_exp_pipe: DEPTH-stage {valid, addr, exp} delay line aligning expected words with RAM q
module ram_bist_exp_pipe #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);
  localparam int W = 1 + ADDR_W + DATA_W;
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= {in_valid, in_addr, in_exp};
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign {out_valid, out_addr, out_exp} = sr[DEPTH-1];
endmodule

// File: rtl/ram_bist_controller.sv
// ram_bist_controller: two-pass (pattern, inverted) write-all/read-all RAM BIST reporting pass or first failing word
module ram_bist_controller
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 8,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic              write_enable,
  input  logic [DATA_W-1:0] q
);
  state_t state;
  logic p;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] cur_pat;
  logic pv;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pe;
  logic mis;
  assign cur_pat = DATA_W'(pattern(32'(cnt), 32'(SEED), p));
  ram_bist_exp_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(RD_LATENCY)) u_pipe (
    .clk(clk), .rst(rst), .in_valid(state == READ), .in_addr(cnt), .in_exp(cur_pat),
    .out_valid(pv), .out_addr(pa), .out_exp(pe)
  );
  assign mis          = pv && (state == READ || state == DRAIN) && q != pe;
  assign busy         = state == WRITE || state == READ || state == DRAIN;
  assign done         = state == DONE;
  assign write_enable = state == WRITE;
  assign write_addr   = write_enable ? cnt : '0;
  assign data         = write_enable ? cur_pat : '0;
  assign read_addr    = (state == WRITE || state == READ) ? cnt : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      p         <= 1'b0;
      cnt       <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      state     <= WRITE;
      p         <= 1'b0;
      cnt       <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (mis) begin
      state     <= DONE;
      cnt       <= '0;
      pass      <= 1'b0;
      fail_addr <= pa;
      fail_exp  <= pe;
      fail_got  <= q;
    end else if (state == WRITE) begin
      cnt   <= cnt + 1'b1;
      state <= &cnt ? READ : WRITE;
    end else if (state == READ) begin
      cnt   <= cnt + 1'b1;
      state <= &cnt ? DRAIN : READ;
    end else if (state == DRAIN) begin
      if (cnt == ADDR_W'(RD_LATENCY - 1)) begin
        cnt   <= '0;
        state <= p ? DONE : WRITE;
        pass  <= p;
        p     <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule
